// File: rtl/sequenciador_varredura.sv
// Channel scan sequencer feeding a 3-to-8 decoder: select A, enable E, programmable dwell, blanking gap.
// Optional build macro MASCARA_EN adds a per-channel enable mask input.
module sequenciador_varredura #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             parar,
  input  logic             pausa,
  input  logic [1:0]       modo,
  input  logic [DIV_W-1:0] periodo,
`ifdef MASCARA_EN
  input  logic [7:0]       mascara,
`endif
  output logic [2:0]       A,
  output logic             E,
  output logic             ocupado,
  output logic             fim
);

  typedef enum logic [1:0] {OCIOSO, VARRE, INTERVALO} estado_t;

  estado_t          estado;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] periodo_l;
  logic [1:0]       modo_l;
  logic             sobe;

  logic [7:0] habilita;
  logic [2:0] a_ini;
  logic [2:0] a_prox;
  logic       sobe_prox;
  logic       ultimo;

`ifdef MASCARA_EN
  assign habilita = mascara;
`else
  assign habilita = 8'hFF;
`endif

  assign a_ini = (modo == 2'b11) ? 3'd7 : 3'd0;

  // Next channel and whether the current one closes a single pass
  always_comb begin
    a_prox    = A + 3'd1;
    sobe_prox = sobe;
    ultimo    = 1'b0;
    case (modo_l)
      2'b00: ultimo = (A == 3'd7);
      2'b01: a_prox = A + 3'd1;
      2'b10: begin
        if (sobe) begin
          if (A == 3'd7) begin
            a_prox    = 3'd6;
            sobe_prox = 1'b0;
          end
        end else if (A == 3'd0) begin
          a_prox    = 3'd1;
          sobe_prox = 1'b1;
        end else begin
          a_prox = A - 3'd1;
        end
      end
      default: begin
        a_prox = A - 3'd1;
        ultimo = (A == 3'd0);
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado    <= OCIOSO;
      A         <= 3'd0;
      E         <= 1'b0;
      ocupado   <= 1'b0;
      fim       <= 1'b0;
      cnt       <= '0;
      sobe      <= 1'b1;
      modo_l    <= 2'b00;
      periodo_l <= '0;
    end else if (parar) begin
      estado  <= OCIOSO;
      E       <= 1'b0;
      ocupado <= 1'b0;
      fim     <= 1'b0;
    end else if (pausa) begin
      fim <= 1'b0;
    end else begin
      case (estado)
        OCIOSO: begin
          E       <= 1'b0;
          ocupado <= 1'b0;
          fim     <= 1'b0;
          if (start) begin
            modo_l    <= modo;
            periodo_l <= periodo;
            A         <= a_ini;
            cnt       <= '0;
            sobe      <= 1'b1;
            estado    <= VARRE;
            E         <= habilita[a_ini];
            ocupado   <= 1'b1;
          end
        end
        VARRE: begin
          E <= habilita[A];
          if (cnt == periodo_l) begin
            cnt    <= '0;
            estado <= INTERVALO;
            E      <= 1'b0;
            fim    <= ultimo;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        INTERVALO: begin
          fim <= 1'b0;
          // A only moves when the gap ends so the decoder never sees a select change while enabled
          if (ultimo) begin
            estado  <= OCIOSO;
            ocupado <= 1'b0;
          end else begin
            A      <= a_prox;
            sobe   <= sobe_prox;
            estado <= VARRE;
            E      <= habilita[a_prox];
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_sequenciador_varredura.sv
// Directed self-checking bench for sequenciador_varredura.
// Mask scenario is compiled only when MASCARA_EN is defined.
module tb_sequenciador_varredura;

  logic       clk = 1'b0;
  logic       rst, start, parar, pausa;
  logic [1:0] modo;
  logic [7:0] periodo;
  logic [2:0] A;
  logic       E, ocupado, fim;
`ifdef MASCARA_EN
  logic [7:0] mascara = 8'hFF;
`endif

  int errors = 0;
  int checks = 0;

  sequenciador_varredura #(.DIV_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .parar(parar), .pausa(pausa),
    .modo(modo), .periodo(periodo),
`ifdef MASCARA_EN
    .mascara(mascara),
`endif
    .A(A), .E(E), .ocupado(ocupado), .fim(fim)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] m, input logic [7:0] p);
    modo = m; periodo = p; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if ({A, E, ocupado, fim} !== 6'b0) begin
      errors++; $display("FAIL reset_init got A=%0d E=%b ocupado=%b fim=%b want all 0", A, E, ocupado, fim);
    end
    rst = 1'b0;
    tick();
    do_start(2'b01, 8'd3);
    repeat (7) tick();
    checks++;
    if (A !== 3'd1 || E !== 1'b1) begin
      errors++; $display("FAIL reset_prescan got A=%0d E=%b want A=1 E=1", A, E);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({A, E, ocupado, fim} !== 6'b0) begin
      errors++; $display("FAIL reset_async got A=%0d E=%b ocupado=%b fim=%b want all 0", A, E, ocupado, fim);
    end
    #2 rst = 1'b0;
    tick();
  endtask

  task automatic test_single_up();
    int cyc = 0, fim_n = 0, fim_at = -1;
    do_start(2'b00, 8'd2);
    for (int s = 0; s < 8; s++) begin
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (A !== 3'(s) || E !== 1'b1 || ocupado !== 1'b1) begin
          errors++; $display("FAIL up_dwell s=%0d d=%0d got A=%0d E=%b ocupado=%b want A=%0d E=1 ocupado=1", s, d, A, E, ocupado, s);
        end
        if (fim) begin fim_n++; fim_at = cyc; end
        cyc++; tick();
      end
      checks++;
      if (E !== 1'b0 || ocupado !== 1'b1) begin
        errors++; $display("FAIL up_gap s=%0d got E=%b ocupado=%b want E=0 ocupado=1", s, E, ocupado);
      end
      if (fim) begin fim_n++; fim_at = cyc; end
      cyc++; tick();
    end
    checks++;
    if (fim_n !== 1 || fim_at !== 31) begin
      errors++; $display("FAIL up_fim got count=%0d at=%0d want count=1 at=31", fim_n, fim_at);
    end
    checks++;
    if (ocupado !== 1'b0 || E !== 1'b0 || fim !== 1'b0 || A !== 3'd7) begin
      errors++; $display("FAIL up_end got ocupado=%b E=%b fim=%b A=%0d want 0 0 0 7", ocupado, E, fim, A);
    end
  endtask

  task automatic test_ping_pong();
    int pp[20] = '{0,1,2,3,4,5,6,7,6,5,4,3,2,1,0,1,2,3,4,5};
    do_start(2'b10, 8'd0);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (A !== 3'(pp[i]) || E !== 1'b1) begin
        errors++; $display("FAIL pp_slot i=%0d got A=%0d E=%b want A=%0d E=1", i, A, E, pp[i]);
      end
      tick();
      checks++;
      if (E !== 1'b0 || fim !== 1'b0) begin
        errors++; $display("FAIL pp_gap i=%0d got E=%b fim=%b want 0 0", i, E, fim);
      end
      tick();
    end
    parar = 1'b1; tick(); parar = 1'b0;
    checks++;
    if (E !== 1'b0 || ocupado !== 1'b0 || fim !== 1'b0) begin
      errors++; $display("FAIL pp_stop got E=%b ocupado=%b fim=%b want 0 0 0", E, ocupado, fim);
    end
  endtask

  task automatic test_single_down();
    int cyc = 0, fim_n = 0, fim_at = -1;
    do_start(2'b11, 8'd1);
    for (int s = 7; s >= 0; s--) begin
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (A !== 3'(s) || E !== 1'b1) begin
          errors++; $display("FAIL down_dwell s=%0d got A=%0d E=%b want A=%0d E=1", s, A, E, s);
        end
        if (fim) begin fim_n++; fim_at = cyc; end
        if (s == 4 && d == 0) begin modo = 2'b00; periodo = 8'd5; start = 1'b1; end
        cyc++; tick();
        start = 1'b0;
      end
      checks++;
      if (E !== 1'b0) begin
        errors++; $display("FAIL down_gap s=%0d got E=%b want 0", s, E);
      end
      if (fim) begin fim_n++; fim_at = cyc; end
      cyc++; tick();
    end
    checks++;
    if (fim_n !== 1 || fim_at !== 23) begin
      errors++; $display("FAIL down_fim got count=%0d at=%0d want count=1 at=23", fim_n, fim_at);
    end
    tick();
    checks++;
    if (ocupado !== 1'b0 || A !== 3'd0) begin
      errors++; $display("FAIL down_end got ocupado=%b A=%0d want 0 0", ocupado, A);
    end
  endtask

  task automatic test_pause_abort();
    int high = 0, budget = 0;
    do_start(2'b01, 8'd3);
    repeat (2) begin high++; tick(); end
    high++;
    pausa = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      high++;
      checks++;
      if (A !== 3'd0 || E !== 1'b1 || ocupado !== 1'b1 || fim !== 1'b0) begin
        errors++; $display("FAIL pause_hold i=%0d got A=%0d E=%b ocupado=%b fim=%b want 0 1 1 0", i, A, E, ocupado, fim);
      end
    end
    pausa = 1'b0;
    high--;
    while (E === 1'b1 && budget < 30) begin high++; budget++; tick(); end
    checks++;
    if (high !== 9) begin
      errors++; $display("FAIL pause_dwell got %0d enabled cycles want 9", high);
    end
    tick();
    checks++;
    if (A !== 3'd1 || E !== 1'b1) begin
      errors++; $display("FAIL pause_next got A=%0d E=%b want A=1 E=1", A, E);
    end
    parar = 1'b1; tick(); parar = 1'b0;
    checks++;
    if (E !== 1'b0 || ocupado !== 1'b0 || fim !== 1'b0 || A !== 3'd1) begin
      errors++; $display("FAIL abort got E=%b ocupado=%b fim=%b A=%0d want 0 0 0 1", E, ocupado, fim, A);
    end
    repeat (4) begin
      tick();
      checks++;
      if (fim !== 1'b0 || ocupado !== 1'b0) begin
        errors++; $display("FAIL abort_idle got fim=%b ocupado=%b want 0 0", fim, ocupado);
      end
    end
  endtask

  task automatic test_start_parar();
    modo = 2'b01; periodo = 8'd0; start = 1'b1; parar = 1'b1;
    tick();
    start = 1'b0; parar = 1'b0;
    checks++;
    if (ocupado !== 1'b0 || E !== 1'b0) begin
      errors++; $display("FAIL start_parar got ocupado=%b E=%b want 0 0", ocupado, E);
    end
    tick();
    checks++;
    if (ocupado !== 1'b0) begin
      errors++; $display("FAIL start_parar_late got ocupado=%b want 0", ocupado);
    end
  endtask

`ifdef MASCARA_EN
  task automatic test_mask();
    int cyc = 0, fim_at = -1;
    logic [7:0] m = 8'b1010_0101;
    mascara = m;
    do_start(2'b00, 8'd1);
    for (int s = 0; s < 8; s++) begin
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (A !== 3'(s) || E !== m[s]) begin
          errors++; $display("FAIL mask_dwell s=%0d got A=%0d E=%b want A=%0d E=%b", s, A, E, s, m[s]);
        end
        if (fim) fim_at = cyc;
        cyc++; tick();
      end
      if (fim) fim_at = cyc;
      cyc++; tick();
    end
    checks++;
    if (fim_at !== 23 || ocupado !== 1'b0) begin
      errors++; $display("FAIL mask_len got fim_at=%0d ocupado=%b want 23 0", fim_at, ocupado);
    end
    mascara = 8'hFF;
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; parar = 1'b0; pausa = 1'b0; modo = 2'b00; periodo = 8'd0;
    test_reset();
    test_single_up();
    test_ping_pong();
    test_single_down();
    test_pause_abort();
    test_start_parar();
`ifdef MASCARA_EN
    test_mask();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
